lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store controller on the consumer side of the main decoder's memory controls (MemWrite, load select).
- Converts the single-cycle core's combinational memory access into a valid/ready handshake with a variable-latency data memory.
- Stalls the core until each access completes.
- Sits between the datapath (ALU result as address, rs2 as write data) and the data memory port.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, word width.
- TIMEOUT, 16, max cycles mem_req may stay unanswered before the access is aborted (legal range 2..255).

Ports:
- clk  in  1  core clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- MemWrite  in  1  store request from decoder.
- MemRead  in  1  load request (decoder ResultSrc==1).
- addr  in  ADDR_WIDTH  access address (ALU result).
- wdata  in  DATA_WIDTH  store data.
- stall  out  1  hold PC/pipeline this cycle.
- rdata  out  DATA_WIDTH  load result, registered.
- rdata_valid  out  1  one-cycle pulse, load data valid.
- err  out  1  one-cycle pulse, access aborted (timeout or misalign).
- mem_req  out  1  memory request valid.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_WIDTH  registered address.
- mem_wdata  out  DATA_WIDTH  registered write data.
- mem_ready  in  1  memory accepts/completes the request.
- mem_rdata  in  DATA_WIDTH  read data, valid when mem_req&&mem_ready.

Behaviour:
- Reset, a decided fact: one clock; reset is synchronous and active-high.
  - Reset forces state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata=0, rdata_valid=0, err=0 and the wait counter to 0.
  - stall=0 on the cycle after reset.
- States: IDLE, REQ, RESP.
- IDLE:
  - If MemRead|MemWrite: latch addr, wdata, mem_we=MemWrite, then go to REQ.
  - stall is combinationally 1 in this cycle.
  - If MemRead and MemWrite are both 1, the access is treated as a store.
- REQ:
  - mem_req=1. mem_addr, mem_wdata and mem_we are held stable until the handshake.
  - stall=1.
  - On mem_req&&mem_ready: capture mem_rdata into rdata (loads only), then go to RESP.
  - Otherwise the wait counter increments. When it reaches TIMEOUT-1 without mem_ready, go to RESP with an abort flag.
- RESP:
  - stall=0, so the core advances exactly one instruction.
  - rdata_valid=1 for a completed load. err=1 for an aborted access. rdata is unchanged on stores and aborts.
  - Unconditionally return to IDLE; the counter clears.
- Back-to-back accesses re-enter REQ via IDLE; there is no bubble beyond the IDLE cycle.
- Minimum load latency with zero-wait memory is 3 cycles: IDLE (request seen) -> REQ (ready) -> RESP (stall low).
- mem_req deasserts on the edge that enters RESP. It never asserts in IDLE or RESP.
- Reset asserted mid-REQ: mem_req=0 on the next cycle; the transaction is abandoned and no rdata_valid or err pulse is produced.
- MemRead/MemWrite changing while in REQ is ignored; the latched values are used.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
- LSU_MISALIGN_CHECK_EN defined:
  - In IDLE, addr[1:0]!=0 skips REQ and goes directly to RESP with err=1.
  - mem_req is never asserted for that access.
- Undefined: no alignment check; addr is passed to mem_addr unchanged.

Decomposition:
- lsu_pkg:
  - lsu_state_t enum {IDLE, REQ, RESP}.
  - LSU_CNT_WIDTH = 8.
  - Default width constants.
- Sub-module lsu_wait_counter (clear, enable, terminal-count output at TIMEOUT-1).
- The FSM and datapath registers stay in lsu_mem_ctrl.

Test Plan:
- Load, zero-wait: MemRead=1, addr=0x10, mem_ready=1 in REQ, mem_rdata=0xDEADBEEF -> mem_req is high for 1 cycle, stall is high for 2 cycles, rdata=0xDEADBEEF with rdata_valid pulsing in cycle 3.
- Store, 3 wait states: MemWrite=1, addr=0x20, wdata=0x12345678, mem_ready after 3 REQ cycles -> mem_we=1, mem_wdata stable for 4 REQ cycles, no rdata_valid, stall drops in RESP.
- Timeout: mem_ready held 0 -> mem_req high exactly 16 cycles, then err pulses once, rdata unchanged, state returns to IDLE.
- Reset mid-access: assert rst on the 2nd REQ cycle -> next cycle mem_req=0, stall=0, no err or rdata_valid pulse.
- Both MemRead and MemWrite=1, addr=0x30 -> store performed (mem_we=1), rdata_valid stays 0.
- With LSU_MISALIGN_CHECK_EN, MemRead addr=0x22 -> err pulses 1 cycle after the request, mem_req never asserts.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store controller.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam int LSU_CNT_WIDTH  = 8;
    localparam int LSU_ADDR_WIDTH = 32;
    localparam int LSU_DATA_WIDTH = 32;
    localparam int LSU_TIMEOUT    = 16;

endpackage

// File: rtl/lsu_wait_counter.sv
// Wait-state counter for an outstanding memory request.
// tc_o flags the last permitted request cycle (count == TIMEOUT-1).
module lsu_wait_counter
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = LSU_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    logic [LSU_CNT_WIDTH-1:0] cnt_q;
    logic [LSU_CNT_WIDTH-1:0] cnt_d;

    // Next count: clear has priority over increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + LSU_CNT_WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LSU_CNT_WIDTH'(TIMEOUT - 1));

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: turns the single-cycle core's memory access into a
// valid/ready handshake with a variable-latency memory, stalling the core
// until the access completes or times out.
// Optional build macro: LSU_MISALIGN_CHECK_EN rejects non-word-aligned
// addresses with err and never issues mem_req for them.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH,
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int TIMEOUT    = LSU_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  stall,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rdata_valid,
    output logic                  err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    lsu_state_t            state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rdata_valid_q, rdata_valid_d;
    logic                  err_q, err_d;

    logic handshake;
    logic cnt_tc;
    logic misalign;

    assign handshake = mem_req_q && mem_ready;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = (addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Wait counter runs only while a request is outstanding and unanswered.
    lsu_wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk   (clk),
        .rst   (rst),
        .clr_i (state_q != REQ),
        .en_i  ((state_q == REQ) && !handshake),
        .tc_o  (cnt_tc)
    );

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d       = state_q;
        mem_req_d     = mem_req_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        err_d         = 1'b0;
        case (state_q)
            IDLE: begin
                if (MemRead || MemWrite) begin
                    mem_addr_d  = addr;
                    mem_wdata_d = wdata;
                    mem_we_d    = MemWrite;
                    if (misalign) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end else begin
                        mem_req_d = 1'b1;
                        state_d   = REQ;
                    end
                end
            end
            REQ: begin
                if (handshake) begin
                    if (!mem_we_q) begin
                        rdata_d       = mem_rdata;
                        rdata_valid_d = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end else if (cnt_tc) begin
                    err_d     = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            err_q         <= err_d;
        end
    end

    // The core is held while a new access is seen in IDLE and throughout REQ.
    assign stall = ((state_q == IDLE) && (MemRead || MemWrite)) || (state_q == REQ);

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign err         = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl: directed plan items plus randomized
// accesses checked against a cycle-count/outcome model of the controller.
module tb_lsu_mem_ctrl;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          MemWrite = 1'b0;
    logic          MemRead = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] wdata = '0;
    logic          stall;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic          err;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    int n_pass  = 0;
    int n_total = 0;
    logic [DW-1:0] model_rdata = '0;

    lsu_mem_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .MemWrite    (MemWrite),
        .MemRead     (MemRead),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .err         (err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete access. waits = number of unanswered REQ cycles before
    // mem_ready; waits >= TO means the memory never answers in time.
    task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdv, input int waits);
        logic is_load;
        logic bad_align;
        logic aborted;
        int   nreq;
        is_load = rd && !wr;
`ifdef LSU_MISALIGN_CHECK_EN
        bad_align = (a[1:0] != 2'b00);
`else
        bad_align = 1'b0;
`endif
        aborted = bad_align || (waits >= TO);
        nreq    = bad_align ? 0 : ((waits >= TO) ? TO : waits + 1);

        MemRead   = rd;
        MemWrite  = wr;
        addr      = a;
        wdata     = wd;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        #1;
        chk("idle_stall", 32'(stall), 32'(1'b1));
        chk("idle_req", 32'(mem_req), 32'(1'b0));
        tick();

        for (int k = 0; k < nreq; k++) begin
            MemRead   = 1'($urandom_range(0, 1));
            MemWrite  = 1'($urandom_range(0, 1));
            addr      = $urandom;
            wdata     = $urandom;
            mem_ready = (k == waits);
            mem_rdata = (k == waits) ? rdv : $urandom;
            @(negedge clk);
            chk("req_mem_req", 32'(mem_req), 32'(1'b1));
            chk("req_stall", 32'(stall), 32'(1'b1));
            chk("req_we", 32'(mem_we), 32'(wr));
            chk("req_addr", mem_addr, a);
            chk("req_wdata", mem_wdata, wd);
            tick();
        end

        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (is_load && !aborted) model_rdata = rdv;
        @(negedge clk);
        chk("resp_stall", 32'(stall), 32'(1'b0));
        chk("resp_mem_req", 32'(mem_req), 32'(1'b0));
        chk("resp_rvalid", 32'(rdata_valid), 32'(is_load && !aborted));
        chk("resp_err", 32'(err), 32'(aborted));
        chk("resp_rdata", rdata, model_rdata);
        tick();

        @(negedge clk);
        chk("post_rvalid", 32'(rdata_valid), 32'(1'b0));
        chk("post_err", 32'(err), 32'(1'b0));
        chk("post_stall", 32'(stall), 32'(1'b0));
        chk("post_mem_req", 32'(mem_req), 32'(1'b0));
    endtask

    initial begin
        logic [31:0] r;
        int          kind;
        int          w;

        // Reset
        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'(1'b0));
        chk("rst_mem_req", 32'(mem_req), 32'(1'b0));
        chk("rst_mem_we", 32'(mem_we), 32'(1'b0));
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rvalid", 32'(rdata_valid), 32'(1'b0));
        chk("rst_err", 32'(err), 32'(1'b0));

        // Zero-wait load, 3-wait store, timeout load, read+write treated as store
        run_access(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 0);
        run_access(1'b0, 1'b1, 32'h20, 32'h12345678, 32'hA5A5A5A5, 3);
        run_access(1'b1, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, TO + 4);
        run_access(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 32'h11111111, 1);
        // Ready on the very last allowed cycle completes rather than aborts
        run_access(1'b1, 1'b0, 32'h50, 32'h0, 32'h76543210, TO - 1);
        // Misaligned load (rejected only when the check is built in)
        run_access(1'b1, 1'b0, 32'h22, 32'h0, 32'h13572468, 0);

        // Reset on the second REQ cycle abandons the access
        MemRead = 1'b1;
        addr    = 32'h40;
        mem_ready = 1'b0;
        tick();
        MemRead = 1'b0;
        @(negedge clk);
        chk("mid_req1", 32'(mem_req), 32'(1'b1));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_rdata = '0;
        @(negedge clk);
        chk("mid_mem_req", 32'(mem_req), 32'(1'b0));
        chk("mid_stall", 32'(stall), 32'(1'b0));
        chk("mid_rvalid", 32'(rdata_valid), 32'(1'b0));
        chk("mid_err", 32'(err), 32'(1'b0));
        chk("mid_rdata", rdata, 32'h0);
        tick();
        @(negedge clk);
        chk("mid_after_rvalid", 32'(rdata_valid), 32'(1'b0));
        chk("mid_after_err", 32'(err), 32'(1'b0));
        chk("mid_after_req", 32'(mem_req), 32'(1'b0));

        // Randomized back-to-back accesses
        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 2));
            r    = $urandom;
            if ($urandom_range(0, 7) != 0) r = r & 32'hFFFF_FFFC;
            w = ($urandom_range(0, 9) == 0) ? TO + int'($urandom_range(0, 2))
                                            : int'($urandom_range(0, 5));
            run_access(kind != 1, kind != 0, r, $urandom, $urandom, w);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Hard bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
